regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 NREQ, 4, number of requesters sharing the register-file write port.
REQ-002 DW, 32, write data width.
REQ-003 AW, 5, register address width; register count is 2**AW (32).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester write request, level, held until own gnt bit seen.
REQ-007 req_addr  input  NREQ*AW  packed destination register per requester (requester i at bits [i*AW +: AW]).
REQ-008 req_data  input  NREQ*DW  packed write data per requester (requester i at bits [i*DW +: DW]).
REQ-009 stall  input  1  datapath hold; blocks write completion while high.
REQ-010 gnt  output  NREQ  one-hot, one-cycle pulse: the write of that requester completes this cycle.
REQ-011 wr_valid  output  1  a captured write is pending or completing.
REQ-012 wr_addr  output  AW  captured destination register.
REQ-013 wr_data  output  DW  captured write data.
REQ-014 wr_en  output  2**AW  one-hot decoded write enable driving the register file.

Function
REQ-015 FSM has two states, IDLE and WRITE, held in a registered state variable.
REQ-016 IDLE, req==0: remain IDLE; wr_valid=0, gnt=0, wr_en=0.
REQ-017 IDLE, req!=0: capture winner index, its addr and data into registers; next state WRITE.
REQ-018 Winner: round-robin, first set req bit scanning upward (wrapping) from index (last_winner+1) mod NREQ.
REQ-019 last_winner updates only when a write completes (WRITE exit), never on capture alone.
REQ-020 WRITE: wr_valid=1; wr_addr/wr_data show captured values, stable for the entire state.
REQ-021 WRITE, stall=1: remain WRITE; gnt=0; wr_en=0.
REQ-022 WRITE, stall=0: gnt[winner]=1 and wr_en bit wr_addr=1 (combinational from state and stall) for exactly this cycle; next state IDLE.
REQ-023 Capture-to-completion latency: one cycle minimum; max throughput one write per two cycles.
REQ-024 req changes while in WRITE are ignored; only sampled in IDLE.
REQ-025 A requester deasserting req before gnt forfeits nothing already captured; the captured write still completes.
REQ-026 wr_en has at most one bit set; zero whenever gnt==0.

Reset
REQ-027 rst_n low: immediately state=IDLE, last_winner=NREQ-1 (requester 0 has top priority after reset), captured regs zero.
REQ-028 During and after reset: gnt=0, wr_valid=0, wr_addr=0, wr_data=0, wr_en=0.
REQ-029 Reset asserted in WRITE drops the pending write; no gnt is issued for it.

Configuration
REQ-030 Macro REGARB_ZERO_PROTECT_EN defined: captured write with wr_addr==0 completes with gnt pulse as normal but wr_en stays all-zero ($zero hard-wired).
REQ-031 Macro undefined: address 0 handled like any other; wr_en[0] pulses on completion.

Structure
REQ-032 Package regarb_pkg holds AW/NREQ defaults, NREGS=2**AW, and the IDLE/WRITE state typedef.
REQ-033 One combinational sub-module regarb_rr_pick (req vector, last_winner -> winner index, any) implements REQ-018.

Verification
REQ-034 Reset release, req=4'b0000 for 10 cycles -> gnt, wr_valid, wr_en all zero throughout.
REQ-035 req=4'b0100, addr2=5'd9, data2=32'hDEAD_BEEF, stall=0 -> next cycle wr_valid=1, wr_addr=9, wr_data=DEADBEEF, wr_en=32'h0000_0200, gnt=4'b0100.
REQ-036 req=4'b1111 held, each requester dropping req on own gnt -> gnt order 0,1,2,3 on alternating cycles.
REQ-037 Capture req1 addr 5'd31, stall=1 for 3 cycles -> wr_valid=1, wr_en=0, gnt=0 for 3 cycles; stall=0 -> wr_en=32'h8000_0000, gnt=4'b0010.
REQ-038 req0 addr 5'd0 -> with REGARB_ZERO_PROTECT_EN gnt=4'b0001, wr_en=0; without it wr_en=32'h0000_0001.
REQ-039 rst_n low during WRITE with stall=1 -> outputs zero at once, no gnt; after release req=4'b1000 -> gnt=4'b1000 first.

Source files
------------

// File: rtl/regarb_pkg.sv
// Shared defaults and FSM state type for the register-file write arbiter.
package regarb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREGS    = 2 ** AW_DEF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/regarb_rr_pick.sv
// Round-robin winner selection: scans upward from (last_winner+1) mod NREQ,
// wrapping, and returns the first requester whose req bit is set.
module regarb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] idx;
  logic          found;

  // Walk the rotated priority order once and latch the first hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_winner) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NREQ requesters onto a single register-file write port.
// Two-state FSM: IDLE samples requests and captures the round-robin winner,
// WRITE holds the captured write until stall drops, then pulses gnt/wr_en.
// Optional macro REGARB_ZERO_PROTECT_EN: writes to register 0 still complete
// (gnt pulses) but never assert wr_en, keeping $zero hard-wired.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 stall,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr_valid,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [(2**AW)-1:0]   wr_en
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [IW-1:0] pick;
  logic          any_req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          en_allowed;

  regarb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req         (req),
    .last_winner (last_q),
    .winner      (pick),
    .any         (any_req)
  );

  // Mux the winning requester's address and data out of the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

`ifdef REGARB_ZERO_PROTECT_EN
  assign en_allowed = (addr_q != '0);
`else
  assign en_allowed = 1'b1;
`endif

  // Next-state and outputs; completion outputs are combinational on stall.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    widx_d   = widx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    gnt      = '0;
    wr_en    = '0;
    wr_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          widx_d  = pick;
          addr_d  = sel_addr;
          data_d  = sel_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_valid = 1'b1;
        if (!stall) begin
          gnt[widx_q] = 1'b1;
          if (en_allowed) begin
            wr_en[addr_q] = 1'b1;
          end
          // Priority rotates only once the write actually lands.
          last_d  = widx_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State, priority pointer and captured write; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      widx_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [31:0]       wr_en;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          idx;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .stall    (stall),
    .gnt      (gnt),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    req   = '0;
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expected decoded enable for a completing write to address a.
  function automatic logic [31:0] exp_en(input logic [4:0] a);
    logic [31:0] one;
    one = 32'd1;
`ifdef REGARB_ZERO_PROTECT_EN
    if (a == 5'd0) return 32'd0;
`endif
    return one << a;
  endfunction

  // Round-robin rule: the set requester closest above last (cyclically) wins.
  function automatic int rr_winner(input logic [3:0] r, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = 99;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last - 1 + 2 * NREQ) % NREQ;
      if (r[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic test_reset;
    rst_n    = 1'b0;
    req      = '0;
    stall    = 1'b0;
    req_addr = '0;
    req_data = '0;
    #3;
    compared++;
    if ({gnt, wr_valid, wr_addr, wr_data, wr_en} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got gnt=%b v=%b a=%h d=%h en=%h, expected all zero",
               gnt, wr_valid, wr_addr, wr_data, wr_en);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      compared++;
      if ({gnt, wr_valid, wr_en} !== '0) begin
        mismatched++;
        $display("FAIL idle_after_reset[%0d]: got gnt=%b v=%b en=%h, expected zero",
                 c, gnt, wr_valid, wr_en);
      end
    end
  endtask

  task automatic test_single;
    set_req(2, 5'd9, 32'hDEAD_BEEF);
    stall = 1'b0;
    tick();
    req = '0;
    #1;
    compared++;
    if (wr_valid !== 1'b1) begin
      mismatched++; $display("FAIL single_valid: got %b expected 1", wr_valid);
    end
    compared++;
    if (wr_addr !== 5'd9) begin
      mismatched++; $display("FAIL single_addr: got %0d expected 9", wr_addr);
    end
    compared++;
    if (wr_data !== 32'hDEAD_BEEF) begin
      mismatched++; $display("FAIL single_data: got %h expected deadbeef", wr_data);
    end
    compared++;
    if (wr_en !== 32'h0000_0200) begin
      mismatched++; $display("FAIL single_en: got %h expected 00000200", wr_en);
    end
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++; $display("FAIL single_gnt: got %b expected 0100", gnt);
    end
    tick();
    #1;
    compared++;
    if ({gnt, wr_valid} !== 5'b0) begin
      mismatched++; $display("FAIL single_after: got gnt=%b v=%b expected zero", gnt, wr_valid);
    end
  endtask

  task automatic test_rr_order;
    int order[$];
    int cyc[$];
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), $urandom);
    for (int c = 0; c < 20 && order.size() < 4; c++) begin
      tick();
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          order.push_back(i);
          cyc.push_back(c);
          req[i] = 1'b0;
        end
      end
    end
    compared++;
    if (order.size() != 4) begin
      mismatched++;
      $display("FAIL rr_count: got %0d grants expected 4 within budget", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        compared++;
        if (order[k] != k) begin
          mismatched++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], k);
        end
        if (k > 0) begin
          compared++;
          if (cyc[k] - cyc[k-1] != 2) begin
            mismatched++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles expected 2", k, cyc[k] - cyc[k-1]);
          end
        end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_stall;
    set_req(1, 5'd31, 32'h1234_5678);
    stall = 1'b1;
    tick();
    req = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      compared++;
      if ({wr_valid, gnt, wr_en} !== {1'b1, 4'b0, 32'b0}) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got v=%b gnt=%b en=%h expected v=1 gnt=0 en=0",
                 c, wr_valid, gnt, wr_en);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    compared++;
    if (wr_en !== 32'h8000_0000 || gnt !== 4'b0010 || wr_addr !== 5'd31) begin
      mismatched++;
      $display("FAIL stall_release: got en=%h gnt=%b a=%0d expected en=80000000 gnt=0010 a=31",
               wr_en, gnt, wr_addr);
    end
    tick();
    #1;
    compared++;
    if (wr_valid !== 1'b0) begin
      mismatched++; $display("FAIL stall_done: got v=%b expected 0", wr_valid);
    end
  endtask

  task automatic test_zero;
    set_req(0, 5'd0, 32'h0BAD_F00D);
    stall = 1'b0;
    tick();
    req = '0;
    #1;
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++; $display("FAIL zero_gnt: got %b expected 0001", gnt);
    end
    compared++;
    if (wr_en !== exp_en(5'd0)) begin
      mismatched++; $display("FAIL zero_en: got %h expected %h", wr_en, exp_en(5'd0));
    end
    tick();
  endtask

  task automatic test_reset_in_write;
    logic seen;
    seen = 1'b0;
    set_req(1, 5'd7, 32'h0000_CAFE);
    stall = 1'b1;
    tick();
    req = '0;
    #1;
    compared++;
    if (wr_valid !== 1'b1) begin
      mismatched++; $display("FAIL rstw_pending: got v=%b expected 1", wr_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({gnt, wr_valid, wr_addr, wr_data, wr_en} !== '0) begin
      mismatched++;
      $display("FAIL rstw_immediate: got gnt=%b v=%b a=%h d=%h en=%h expected all zero",
               gnt, wr_valid, wr_addr, wr_data, wr_en);
    end
    stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (gnt != 0) seen = 1'b1;
    end
    rst_n = 1'b1;
    #1;
    if (gnt != 0) seen = 1'b1;
    compared++;
    if (seen !== 1'b0) begin
      mismatched++; $display("FAIL rstw_no_gnt: got gnt during reset, expected none");
    end
    set_req(3, 5'd3, 32'h3333_0003);
    tick();
    req = '0;
    #1;
    compared++;
    if (gnt !== 4'b1000) begin
      mismatched++; $display("FAIL rstw_first: got %b expected 1000", gnt);
    end
    tick();
  endtask

  task automatic test_random;
    wr_t         pend[$];
    wr_t         w;
    int          last;
    int          win;
    logic [3:0]  e_gnt;
    logic [31:0] e_en;
    apply_reset();
    last = NREQ - 1;
    for (int c = 0; c < 400; c++) begin
      req      = 4'($urandom_range(0, 15));
      req_addr = {$urandom, $urandom} & {(NREQ*AW){1'b1}};
      req_data = {$urandom, $urandom, $urandom, $urandom};
      stall    = ($urandom_range(0, 3) == 0);
      #1;
      e_gnt = '0;
      e_en  = '0;
      if (pend.size() != 0 && !stall) begin
        e_gnt[pend[0].idx] = 1'b1;
        e_en = exp_en(pend[0].addr);
      end
      compared++;
      if (wr_valid !== (pend.size() != 0)) begin
        mismatched++;
        $display("FAIL rand_valid[%0d]: got %b expected %b", c, wr_valid, pend.size() != 0);
      end
      compared++;
      if (gnt !== e_gnt || wr_en !== e_en) begin
        mismatched++;
        $display("FAIL rand_gnt_en[%0d]: got gnt=%b en=%h expected gnt=%b en=%h",
                 c, gnt, wr_en, e_gnt, e_en);
      end
      if (pend.size() != 0) begin
        compared++;
        if (wr_addr !== pend[0].addr || wr_data !== pend[0].data) begin
          mismatched++;
          $display("FAIL rand_payload[%0d]: got a=%0d d=%h expected a=%0d d=%h",
                   c, wr_addr, wr_data, pend[0].addr, pend[0].data);
        end
      end
      // Advance the reference model to the state after the coming edge.
      if (pend.size() != 0) begin
        if (!stall) begin
          last = pend[0].idx;
          pend.delete();
        end
      end else if (req != 0) begin
        win    = rr_winner(req, last);
        w.idx  = win;
        w.addr = req_addr[win*AW +: AW];
        w.data = req_data[win*DW +: DW];
        pend.push_back(w);
      end
      tick();
    end
    req   = '0;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_stall();
    test_zero();
    test_reset_in_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
